// File: rtl/k007232_host.sv
// k007232_host: queued host-side register write/read cycle generator.
// Read cycles are built only when K007232_HOST_READ_EN is defined.
module k007232_host #(
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       CLK,
    input  logic       NRES,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_reg,
    input  logic [7:0] cmd_data,
    input  logic       cmd_rd,
    output logic [3:0] AB,
    output logic [7:0] DB,
    output logic       DB_OE,
    input  logic [7:0] DB_IN,
    output logic       DACS,
    output logic       NRCS,
    output logic       NRD,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    typedef struct packed {
        logic       rd;
        logic [3:0] rg;
        logic [7:0] data;
    } entry_t;

    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    entry_t        wr_entry;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_n;
    logic          accept;
    logic          illegal;
    logic          push;
    logic          ill_push;
    logic          pop;
    logic          empty;
    logic          avail;

    state_t        state;
    state_t        state_n;
    logic [7:0]    cnt;
    logic [7:0]    cnt_n;
    logic          cur_rd;
    logic          cur_rd_n;
    logic          capture;
    logic [3:0]    ab_n;
    logic [7:0]    db_n;
    logic          db_oe_n;
    logic          dacs_n;
    logic          rstb_n;
    logic          rstb;

    assign illegal  = cmd_reg[3:1] == 3'b111;
    assign accept   = cmd_valid && cmd_ready;
    assign push     = accept && !illegal;
    assign ill_push = accept && illegal;
    assign empty    = count == '0;
    assign head     = mem[rd_ptr];
    assign count_n  = count + (AW+1)'(push) - (AW+1)'(pop);

`ifdef K007232_HOST_READ_EN
    assign wr_entry = '{rd: cmd_rd, rg: cmd_reg, data: cmd_data};
`else
    assign wr_entry = '{rd: 1'b0, rg: cmd_reg, data: cmd_data};
`endif

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    // avail lags the FIFO by one cycle so an idle issue never
    // reads an entry on the same edge it was written
    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            avail     <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_n;
            avail     <= !empty;
            cmd_ready <= count_n != (AW+1)'(FIFO_DEPTH);
            busy      <= (count_n != '0) || (state_n != IDLE);
        end
    end

    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            state  <= IDLE;
            cnt    <= '0;
            cur_rd <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            cur_rd <= cur_rd_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 8'd1;
        pop      = 1'b0;
        capture  = 1'b0;
        cur_rd_n = cur_rd;
        ab_n     = AB;
        db_n     = DB;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (avail && !empty) begin
                    pop     = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (cnt == 8'(SETUP_CYC - 1)) begin
                    cnt_n   = '0;
                    state_n = STROBE;
                end
            end
            STROBE: begin
                if (cnt == 8'(STROBE_CYC - 1)) begin
                    cnt_n   = '0;
                    capture = cur_rd;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (cnt == 8'(HOLD_CYC - 1)) begin
                    cnt_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = SETUP;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (pop) begin
            cur_rd_n = head.rd;
            ab_n     = head.rg ^ 4'b0001;
            db_n     = head.data;
        end
        db_oe_n = (state_n != IDLE) && !cur_rd_n;
        dacs_n  = !((state_n == STROBE) && !cur_rd_n);
        rstb_n  = !((state_n == STROBE) && cur_rd_n);
    end

    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            AB    <= '0;
            DB    <= '0;
            DB_OE <= 1'b0;
            DACS  <= 1'b1;
            rstb  <= 1'b1;
        end else begin
            AB    <= ab_n;
            DB    <= db_n;
            DB_OE <= db_oe_n;
            DACS  <= dacs_n;
            rstb  <= rstb_n;
        end
    end

    assign NRCS = rstb;
    assign NRD  = rstb;

`ifdef K007232_HOST_READ_EN
    logic [1:0] err_pend;
    logic [1:0] err_pend_n;
    logic [2:0] err_tot;
    logic       err_n;

    // an error that would land on a rd_valid cycle is deferred
    always_comb begin
        err_tot = {1'b0, err_pend} + 3'(ill_push);
        if (capture) begin
            err_n      = 1'b0;
            err_pend_n = (err_tot > 3'd3) ? 2'd3 : err_tot[1:0];
        end else begin
            err_n      = err_tot != '0;
            err_pend_n = (err_tot != '0) ? 2'(err_tot - 3'd1) : 2'd0;
        end
    end

    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
            err_pend <= '0;
        end else begin
            if (capture) rd_data <= DB_IN;
            rd_valid <= capture;
            err      <= err_n;
            err_pend <= err_pend_n;
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^{cmd_rd, DB_IN, capture};
    assign rd_data   = '0;
    assign rd_valid  = 1'b0;

    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) err <= 1'b0;
        else       err <= ill_push;
    end
`endif

endmodule

// File: tb/tb_k007232_host.sv
// Directed self-checking bench for k007232_host (default and
// non-default timing instances; read path when K007232_HOST_READ_EN).
module tb_k007232_host;

    logic       CLK = 1'b0;
    logic       NRES = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rd = 1'b0;
    logic [3:0] cmd_reg = '0;
    logic [7:0] cmd_data = '0;
    logic [7:0] DB_IN = '0;

    logic       cmd_ready, DB_OE, DACS, NRCS, NRD, rd_valid, busy, err;
    logic [3:0] AB;
    logic [7:0] DB, rd_data;

    logic       cmd_ready_b, DB_OE_b, DACS_b, NRCS_b, NRD_b;
    logic       rd_valid_b, busy_b, err_b;
    logic [3:0] AB_b;
    logic [7:0] DB_b, rd_data_b;

    k007232_host dut (
        .CLK(CLK), .NRES(NRES), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_reg(cmd_reg),
        .cmd_data(cmd_data), .cmd_rd(cmd_rd), .AB(AB), .DB(DB),
        .DB_OE(DB_OE), .DB_IN(DB_IN), .DACS(DACS), .NRCS(NRCS),
        .NRD(NRD), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .err(err)
    );

    k007232_host #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut_b (
        .CLK(CLK), .NRES(NRES), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready_b), .cmd_reg(cmd_reg),
        .cmd_data(cmd_data), .cmd_rd(cmd_rd), .AB(AB_b), .DB(DB_b),
        .DB_OE(DB_OE_b), .DB_IN(DB_IN), .DACS(DACS_b), .NRCS(NRCS_b),
        .NRD(NRD_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .busy(busy_b), .err(err_b)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int         cyc = 0;
    logic       mon_on = 1'b0;
    logic       dacs_q = 1'b1;
    int         npulse = 0;
    int         nrv = 0;
    logic [3:0] p_ab [16];
    logic [7:0] p_db [16];
    int         p_cyc [16];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (mon_on && dacs_q && !DACS && npulse < 16) begin
            p_ab[npulse]  = AB;
            p_db[npulse]  = DB;
            p_cyc[npulse] = cyc;
            npulse++;
        end
        if (mon_on && rd_valid) nrv++;
        dacs_q = DACS;
    end

    task automatic send(input logic [3:0] r, input logic [7:0] d,
                        input logic rd);
        @(posedge CLK); #1;
        cmd_valid = 1'b1; cmd_reg = r; cmd_data = d; cmd_rd = rd;
        @(posedge CLK); #1;
        cmd_valid = 1'b0; cmd_rd = 1'b0;
    endtask

    // {AB,DB,DB_OE,DACS,NRCS,NRD,rd_valid,busy}
    logic [17:0] exp1 [7] = '{
        {4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
        {4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
        {4'h1, 8'hF8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
        {4'h1, 8'hF8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1},
        {4'h1, 8'hF8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1},
        {4'h1, 8'hF8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
        {4'h1, 8'hF8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}
    };

    logic [3:0] breg [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd13, 4'd5};
    logic [7:0] bdat [7] = '{8'hF8, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    logic [3:0] bab  [7] = '{4'h1, 4'h0, 4'h3, 4'h2, 4'h5, 4'hC, 4'h4};

    // {AB,DACS,DB_OE,busy} of the slow-timing instance
    logic [6:0] exp5 [10] = '{
        {4'h0, 1'b1, 1'b0, 1'b1}, {4'h0, 1'b1, 1'b0, 1'b1},
        {4'h2, 1'b1, 1'b1, 1'b1}, {4'h2, 1'b1, 1'b1, 1'b1},
        {4'h2, 1'b0, 1'b1, 1'b1}, {4'h2, 1'b0, 1'b1, 1'b1},
        {4'h2, 1'b0, 1'b1, 1'b1}, {4'h2, 1'b1, 1'b1, 1'b1},
        {4'h2, 1'b1, 1'b1, 1'b1}, {4'h2, 1'b1, 1'b0, 1'b0}
    };

    // {AB,DACS,DB_OE,NRCS,NRD,rd_valid}
`ifdef K007232_HOST_READ_EN
    logic [8:0] exp6 [7] = '{
        {4'h2, 5'b10110}, {4'h2, 5'b10110}, {4'hD, 5'b10110},
        {4'hD, 5'b10000}, {4'hD, 5'b10000}, {4'hD, 5'b10111},
        {4'hD, 5'b10110}
    };
`else
    logic [8:0] exp6 [7] = '{
        {4'h2, 5'b10110}, {4'h2, 5'b10110}, {4'hD, 5'b11110},
        {4'hD, 5'b01110}, {4'hD, 5'b01110}, {4'hD, 5'b11110},
        {4'hD, 5'b10110}
    };
`endif

    logic acc;
    logic saw_full;
    logic busy_seen;

    initial begin
        #12;
        check("reset_state",
              {AB, DB, DB_OE, DACS, NRCS, NRD, rd_data, rd_valid,
               busy, err, cmd_ready},
              {4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0,
               1'b0, 1'b0, 1'b1});
        #8 NRES = 1'b1;

        send(4'd0, 8'hF8, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            check($sformatf("wr1_c%0d", i),
                  {AB, DB, DB_OE, DACS, NRCS, NRD, rd_valid, busy},
                  exp1[i]);
        end
        repeat (4) @(negedge CLK);

        npulse = 0; mon_on = 1'b1; saw_full = 1'b0;
        @(posedge CLK); #1;
        for (int k = 0; k < 7; k++) begin
            cmd_valid = 1'b1; cmd_reg = breg[k]; cmd_data = bdat[k];
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                @(negedge CLK);
                acc = cmd_ready;
                if (!cmd_ready) saw_full = 1'b1;
                @(posedge CLK); #1;
            end
            check($sformatf("burst_acc%0d", k), acc, 1);
        end
        cmd_valid = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge CLK);
            if (!busy) break;
        end
        check("burst_drain", busy, 0);
        repeat (2) @(negedge CLK);
        mon_on = 1'b0;
        check("burst_full", saw_full, 1);
        check("burst_npulse", npulse, 7);
        for (int k = 0; k < 7 && k < npulse; k++) begin
            check($sformatf("burst_ab%0d", k), p_ab[k], bab[k]);
            check($sformatf("burst_db%0d", k), p_db[k], bdat[k]);
            if (k > 0)
                check($sformatf("burst_gap%0d", k),
                      p_cyc[k] - p_cyc[k-1], 4);
        end

        npulse = 0; mon_on = 1'b1;
        @(posedge CLK); #1;
        cmd_valid = 1'b1; cmd_reg = 4'd14; cmd_data = 8'hAA;
        @(negedge CLK);
        check("ill_ready", cmd_ready, 1);
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        @(negedge CLK);
        check("ill_err", {err, busy}, 2'b10);
        @(negedge CLK);
        check("ill_err_end", {err, busy}, 2'b00);
        busy_seen = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            busy_seen |= busy;
        end
        mon_on = 1'b0;
        check("ill_busy", busy_seen, 0);
        check("ill_strobes", npulse, 0);

        @(posedge CLK); #1;
        cmd_valid = 1'b1; cmd_reg = 4'd2; cmd_data = 8'h11;
        @(posedge CLK); #1;
        cmd_reg = 4'd3; cmd_data = 8'h22;
        @(posedge CLK); #1;
        cmd_reg = 4'd4; cmd_data = 8'h33;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("rst_pre", DACS, 0);
        #2 NRES = 1'b0;
        #1;
        check("rst_async",
              {DACS, DB_OE, busy, cmd_ready, AB, DACS_b, DB_OE_b},
              {1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0});
        @(negedge CLK);
        @(posedge CLK); #3;
        NRES = 1'b1;
        npulse = 0; mon_on = 1'b1; busy_seen = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            busy_seen |= busy;
        end
        mon_on = 1'b0;
        check("rst_busy", busy_seen, 0);
        check("rst_strobes", npulse, 0);

        send(4'd3, 8'h55, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check($sformatf("slow_c%0d", i),
                  {AB_b, DACS_b, DB_OE_b, busy_b}, exp5[i]);
        end
        repeat (4) @(negedge CLK);

        DB_IN = 8'h5A;
        nrv = 0; mon_on = 1'b1;
        send(4'd12, 8'h3C, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            check($sformatf("rd_c%0d", i),
                  {AB, DACS, DB_OE, NRCS, NRD, rd_valid}, exp6[i]);
        end
        repeat (3) @(negedge CLK);
        mon_on = 1'b0;
`ifdef K007232_HOST_READ_EN
        check("rd_data", rd_data, 8'h5A);
        check("rd_pulses", nrv, 1);
`else
        check("rd_data", rd_data, 8'h00);
        check("rd_pulses", nrv, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
